// File: rtl/rr_arb_tree.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_tree
// Brief    : Round-robin arbitration tree. Priority comes from an internal
//            counter or the external rr_i pointer. Optional macro
//            RR_ARB_TREE_LOCK_EN holds the decision stable across a stall.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_tree #(
   parameter int unsigned NumIn     = 4,
   parameter int unsigned DataWidth = 32,
   parameter bit          ExtPrio   = 1'b0,
   localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic [IdxWidth-1:0]          rr_i,
   input  logic [NumIn-1:0]             req_i,
   output logic [NumIn-1:0]             gnt_o,
   input  logic [NumIn*DataWidth-1:0]   data_i,
   input  logic                         gnt_i,
   output logic                         req_o,
   output logic [DataWidth-1:0]         data_o,
   output logic [IdxWidth-1:0]          idx_o
);

   localparam int unsigned c_num_p = 2 ** IdxWidth;

   logic [IdxWidth-1:0]  w_rr;
   logic [c_num_p-1:0]   w_req_pad;
   logic [c_num_p-1:0]   w_tree_req;
   logic [IdxWidth-1:0]  w_tree_idx [c_num_p];
   logic [DataWidth-1:0] w_leaf_data [c_num_p];
   logic [IdxWidth-1:0]  w_root_idx;
   logic                 w_hs;
   logic                 w_unused;

   // Some inputs are dead for certain parameter sets; fold them here.
   assign w_unused  = ^{clk_i, rst_i, flush_i, rr_i};

   assign w_req_pad = c_num_p'(req_i);
   assign req_o     = |req_i;
   assign w_hs      = req_o & gnt_i;

   for (genvar i = 0; i < c_num_p; i++) begin : g_leaf
      if (i < NumIn) begin : g_real
         assign w_leaf_data[i] = data_i[i*DataWidth +: DataWidth];
      end else begin : g_pad
         assign w_leaf_data[i] = '0;
      end
   end

   // Tree evaluated in place, leaves upward: node k of a level reads its
   // children at 2k (lower) and 2k+1 (upper) of the level below.
   always_comb begin
      w_tree_req = w_req_pad;
      for (int i = 0; i < c_num_p; i++) begin
         w_tree_idx[i] = IdxWidth'(i);
      end
      for (int l = IdxWidth - 1; l >= 0; l--) begin
         for (int k = 0; k < (1 << l); k++) begin
            if (!w_tree_req[2*k] || (w_tree_req[2*k+1] && w_rr[IdxWidth-1-l])) begin
               w_tree_idx[k] = w_tree_idx[2*k+1];
            end else begin
               w_tree_idx[k] = w_tree_idx[2*k];
            end
            w_tree_req[k] = w_tree_req[2*k] | w_tree_req[2*k+1];
         end
      end
   end

   if (ExtPrio) begin : g_ext_prio
      assign w_rr = rr_i;
   end else if (NumIn > 1) begin : g_int_cnt
      logic [IdxWidth-1:0] r_rr_q;
      always_ff @(posedge clk_i) begin
         if (rst_i || flush_i) begin
            r_rr_q <= '0;
         end else if (w_hs) begin
            r_rr_q <= (r_rr_q == IdxWidth'(NumIn - 1)) ? '0 : r_rr_q + IdxWidth'(1);
         end
      end
      assign w_rr = r_rr_q;
   end else begin : g_single
      assign w_rr = '0;
   end

`ifdef RR_ARB_TREE_LOCK_EN
   logic                r_lock;
   logic [IdxWidth-1:0] r_lock_idx;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i || w_hs) begin
         r_lock <= 1'b0;
      end else if (req_o) begin
         r_lock <= 1'b1;
      end
      if (rst_i) begin
         r_lock_idx <= '0;
      end else if (req_o && !gnt_i) begin
         r_lock_idx <= idx_o;
      end
   end

   assign w_root_idx = r_lock ? r_lock_idx : w_tree_idx[0];
`else
   assign w_root_idx = w_tree_idx[0];
`endif

   assign idx_o  = req_o ? w_root_idx : '0;
   assign data_o = w_leaf_data[idx_o];

   for (genvar i = 0; i < NumIn; i++) begin : g_gnt
      assign gnt_o[i] = gnt_i & req_o & (idx_o == IdxWidth'(i));
   end

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_tree.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_tree
// Brief    : Directed self-checking bench for rr_arb_tree (internal counter,
//            external pointer, 3-input wrap, optional lock behaviour).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb_tree;

`ifdef RR_ARB_TREE_LOCK_EN
   localparam bit c_lock = 1'b1;
`else
   localparam bit c_lock = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic [127:0] data_a;

   logic [3:0]  req_a, gnt_oa;
   logic        gnt_a, flush_a, req_oa;
   logic [1:0]  rr_a, idx_oa;
   logic [31:0] data_oa;

   logic [3:0]  req_e, gnt_oe;
   logic        gnt_e, flush_e, req_oe;
   logic [1:0]  rr_e, idx_oe;
   logic [31:0] data_oe;

   logic [2:0]  req_c, gnt_oc;
   logic        gnt_c, flush_c, req_oc;
   logic [1:0]  rr_c, idx_oc;
   logic [31:0] data_oc;

   int n_vec = 0;
   int n_err = 0;

   rr_arb_tree #(.NumIn(4), .DataWidth(32), .ExtPrio(1'b0)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .rr_i(rr_a), .req_i(req_a),
      .gnt_o(gnt_oa), .data_i(data_a), .gnt_i(gnt_a), .req_o(req_oa),
      .data_o(data_oa), .idx_o(idx_oa)
   );

   rr_arb_tree #(.NumIn(4), .DataWidth(32), .ExtPrio(1'b1)) u_ext (
      .clk_i(clk), .rst_i(rst), .flush_i(flush_e), .rr_i(rr_e), .req_i(req_e),
      .gnt_o(gnt_oe), .data_i(data_a), .gnt_i(gnt_e), .req_o(req_oe),
      .data_o(data_oe), .idx_o(idx_oe)
   );

   rr_arb_tree #(.NumIn(3), .DataWidth(32), .ExtPrio(1'b0)) u_n3 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush_c), .rr_i(rr_c), .req_i(req_c),
      .gnt_o(gnt_oc), .data_i(data_a[95:0]), .gnt_i(gnt_c), .req_o(req_oc),
      .data_o(data_oc), .idx_o(idx_oc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word(input int i);
      return 32'hA0A0_0000 + 32'(i) * 32'h0101_0001;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      data_a = {word(3), word(2), word(1), word(0)};
      rst = 1'b1;
      req_a = '0; gnt_a = 1'b0; flush_a = 1'b0; rr_a = '0;
      req_e = '0; gnt_e = 1'b0; flush_e = 1'b0; rr_e = '0;
      req_c = '0; gnt_c = 1'b0; flush_c = 1'b0; rr_c = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_o", 32'(req_oa), 32'd0);
      check("rst_gnt_o", 32'(gnt_oa), 32'd0);
      check("rst_idx_o", 32'(idx_oa), 32'd0);
      check("rst_data_o", data_oa, 32'hA0A0_0000);

      // Full-load rotation with internal counter
      @(negedge clk);
      rst = 1'b0; req_a = 4'b1111; gnt_a = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("rot_idx", 32'(idx_oa), 32'(k % 4));
         check("rot_gnt", 32'(gnt_oa), 32'(1 << (k % 4)));
         if (k == 3) check("rot_data", data_oa, 32'hA3A3_0003);
         if (k < 4) @(negedge clk);
      end

      // Downstream stall from pointer 0
      req_a = 4'b0100; gnt_a = 1'b0;
      #1;
      check("stall_req_o", 32'(req_oa), 32'd1);
      check("stall_idx", 32'(idx_oa), 32'd2);
      check("stall_data", data_oa, 32'hA2A2_0002);
      check("stall_gnt", 32'(gnt_oa), 32'd0);
      @(negedge clk);
      req_a = 4'b1111;
      #1;
      check("stall_hold", 32'(idx_oa), 32'd0);

      // Advance to pointer 2, then flush together with a handshake
      gnt_a = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("pre_flush", 32'(idx_oa), 32'd2);
      flush_a = 1'b1;
      @(negedge clk);
      flush_a = 1'b0; gnt_a = 1'b0;
      #1;
      check("flush_idx", 32'(idx_oa), 32'd0);

      // Reset in the middle of traffic
      gnt_a = 1'b1;
      @(negedge clk);
      #1;
      check("pre_rst", 32'(idx_oa), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; gnt_a = 1'b0;
      #1;
      check("mid_rst", 32'(idx_oa), 32'd0);
      req_a = '0;

      // External priority pointer
      @(negedge clk);
      req_e = 4'b1111; rr_e = 2'd3; gnt_e = 1'b1;
      #1;
      check("ext_rr3_all", 32'(idx_oe), 32'd3);
      check("ext_rr3_gnt", 32'(gnt_oe), 32'b1000);
      req_e = 4'b0111;
      #1;
      check("ext_rr3_0111", 32'(idx_oe), 32'd2);
      rr_e = 2'd1; req_e = 4'b0101;
      #1;
      check("ext_rr1_0101", 32'(idx_oe), 32'd0);

      // Stall then pointer change: held only when the lock is built in
      gnt_e = 1'b0; req_e = 4'b0011; rr_e = 2'd0;
      #1;
      check("lock_base", 32'(idx_oe), 32'd0);
      @(negedge clk);
      rr_e = 2'd1;
      #1;
      check("lock_hold_idx", 32'(idx_oe), c_lock ? 32'd0 : 32'd1);
      gnt_e = 1'b1;
      #1;
      check("lock_gnt", 32'(gnt_oe), c_lock ? 32'b0001 : 32'b0010);
      @(negedge clk);
      gnt_e = 1'b0;
      #1;
      check("lock_release", 32'(idx_oe), 32'd1);
      req_e = '0;

      // Three requesters: pointer wraps 2 -> 0
      @(negedge clk);
      req_c = 3'b111; gnt_c = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         check("n3_idx", 32'(idx_oc), 32'(k % 3));
         check("n3_gnt", 32'(gnt_oc), 32'(1 << (k % 3)));
         if (k == 2) check("n3_data", data_oc, 32'hA2A2_0002);
         if (k < 5) @(negedge clk);
      end
      req_c = '0; gnt_c = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
